// File: rtl/obi_arb_pkg.sv
// -----------------------------------------------------------------------------
// obi_arb_pkg
// Shared defaults and types for the OBI round-robin arbiter slice.
//   - OBI_*_DEFAULT     : default widths and sizes used as parameter defaults
//   - obi_req_info_t    : one address-phase payload at the default 32-bit widths
// Nothing in here depends on module parameters; width-dependent types are
// declared locally where they are used.
// -----------------------------------------------------------------------------
package obi_arb_pkg;

    localparam int unsigned OBI_NUM_REQ_DEFAULT = 2;
    localparam int unsigned OBI_ADDRW_DEFAULT   = 32;
    localparam int unsigned OBI_DATAW_DEFAULT   = 32;
    localparam int unsigned OBI_STRBW_DEFAULT   = OBI_DATAW_DEFAULT / 8;
    localparam int unsigned OBI_MAX_OUT_DEFAULT = 4;

    // Address-phase payload of one OBI request (default widths).
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } obi_req_info_t;

endpackage

// File: rtl/obi_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// obi_rr_arbiter_if
// Bundles the requester-side (s_*) and bridge-side (m_*) OBI signals of the
// arbiter.
//   modport slave  : the arbiter's view (takes requests, drives the bridge)
//   modport master : the environment's view (requesters + bridge model)
// s_* vectors are indexed by requester number.
// -----------------------------------------------------------------------------
interface obi_rr_arbiter_if
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = OBI_NUM_REQ_DEFAULT,
    parameter int unsigned OBI_ADDRW = OBI_ADDRW_DEFAULT,
    parameter int unsigned OBI_DATAW = OBI_DATAW_DEFAULT,
    parameter int unsigned OBI_STRBW = OBI_DATAW / 8
) ();

    // requester side
    logic [NUM_REQ-1:0]                s_req_i;
    logic [NUM_REQ-1:0][OBI_ADDRW-1:0] s_addr_i;
    logic [NUM_REQ-1:0]                s_we_i;
    logic [NUM_REQ-1:0][OBI_DATAW-1:0] s_wdata_i;
    logic [NUM_REQ-1:0][OBI_STRBW-1:0] s_be_i;
    logic [NUM_REQ-1:0]                s_gnt_o;
    logic [NUM_REQ-1:0]                s_rvalid_o;
    logic [NUM_REQ-1:0][OBI_DATAW-1:0] s_rdata_o;

    // bridge side
    logic                              m_req_o;
    logic [OBI_ADDRW-1:0]              m_addr_o;
    logic                              m_we_o;
    logic [OBI_DATAW-1:0]              m_wdata_o;
    logic [OBI_STRBW-1:0]              m_be_o;
    logic                              m_gnt_i;
    logic                              m_rvalid_i;
    logic [OBI_DATAW-1:0]              m_rdata_i;

    modport slave (
        input  s_req_i, s_addr_i, s_we_i, s_wdata_i, s_be_i,
        output s_gnt_o, s_rvalid_o, s_rdata_o,
        output m_req_o, m_addr_o, m_we_o, m_wdata_o, m_be_o,
        input  m_gnt_i, m_rvalid_i, m_rdata_i
    );

    modport master (
        output s_req_i, s_addr_i, s_we_i, s_wdata_i, s_be_i,
        input  s_gnt_o, s_rvalid_o, s_rdata_o,
        input  m_req_o, m_addr_o, m_we_o, m_wdata_o, m_be_o,
        output m_gnt_i, m_rvalid_i, m_rdata_i
    );

endinterface

// File: rtl/obi_rr_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// obi_arb_id_fifo
// Synchronous FIFO of requester indices, one entry per granted-but-unanswered
// transaction. The head is readable combinationally so a response can be
// routed in the same cycle rvalid arrives.
// Ports:
//   clk_i, arst_ni : clock, asynchronous active-low reset
//   push_i, data_i : enqueue data_i (ignored when full)
//   pop_i          : dequeue head (ignored when empty)
//   full_o, empty_o, count_o : occupancy
//   head_o         : oldest entry
// Push and pop in the same cycle leave the count unchanged; the pop consumes
// the entry that was at the head before the push.
// -----------------------------------------------------------------------------
module obi_arb_id_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned IDXW  = 1,
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    input  logic            push_i,
    input  logic [IDXW-1:0] data_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [CNTW-1:0] count_o,
    output logic [IDXW-1:0] head_o
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][IDXW-1:0] mem_q, mem_d;
    logic [PTRW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]            count_q, count_d;
    logic                       do_push, do_pop;

    // Explicit wrap keeps the pointer correct for DEPTH == 1 as well.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == PTRW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTRW'(1);
    endfunction

    assign full_o  = (count_q == CNTW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        assign mem_d[gi] = (do_push && (wr_ptr_q == PTRW'(gi))) ? data_i : mem_q[gi];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// obi_rr_arbiter
// Shares one OBI master port (towards the OBI-to-AXI bridge) between NUM_REQ
// OBI requesters with round-robin arbitration. Once an address phase is
// presented without a grant the winner is locked until the handshake. The
// index of every granted transaction is queued so responses (which the bridge
// returns in order) are steered back to the requester that issued them.
// Ports:
//   clk_i, arst_ni : clock, asynchronous active-low reset
//   bus (slave)    : s_* per-requester OBI ports, m_* bridge-facing OBI port
//   err_o          : sticky protocol error (request dropped while locked,
//                    or rvalid with nothing outstanding)
// -----------------------------------------------------------------------------
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = OBI_NUM_REQ_DEFAULT,
    parameter int unsigned OBI_ADDRW       = OBI_ADDRW_DEFAULT,
    parameter int unsigned OBI_DATAW       = OBI_DATAW_DEFAULT,
    parameter int unsigned OBI_STRBW       = OBI_DATAW / 8,
    parameter int unsigned MAX_OUTSTANDING = OBI_MAX_OUT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    obi_rr_arbiter_if.slave  bus,
    output logic             err_o
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);
    localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [IDXW-1:0] locked_idx_q, locked_idx_d;
    logic            err_q, err_d;

    logic [IDXW-1:0] sel_scan, sel;
    logic [IDXW:0]   cand;
    logic            scan_hit;
    logic            any_req;
    logic            m_req;
    logic            handshake;
    logic            pop;

    logic            fifo_full, fifo_empty;
    logic [CNTW-1:0] fifo_count;
    logic [IDXW-1:0] fifo_head;

    logic [OBI_ADDRW-1:0]              addr_mux;
    logic                              we_mux;
    logic [OBI_DATAW-1:0]              wdata_mux;
    logic [OBI_STRBW-1:0]              be_mux;
    logic [NUM_REQ-1:0]                gnt_vec;
    logic [NUM_REQ-1:0]                rvalid_vec;
    logic [NUM_REQ-1:0][OBI_DATAW-1:0] rdata_vec;

    // ---------------------------------------------------------------- select
    // First requester at or after rr_ptr, wrapping around NUM_REQ.
    always_comb begin
        sel_scan = rr_ptr_q;
        scan_hit = 1'b0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDXW + 1)'(i);
            if (cand >= (IDXW + 1)'(NUM_REQ)) begin
                cand = cand - (IDXW + 1)'(NUM_REQ);
            end
            if (!scan_hit && bus.s_req_i[cand[IDXW-1:0]]) begin
                sel_scan = cand[IDXW-1:0];
                scan_hit = 1'b1;
            end
        end
    end

    assign sel     = lock_q ? locked_idx_q : sel_scan;
    assign any_req = |bus.s_req_i;

    // Gating with arst_ni keeps the bridge request low while reset is held,
    // even though requesters may already be asserting.
    assign m_req     = arst_ni & (lock_q | any_req) &
                       (fifo_count < CNTW'(MAX_OUTSTANDING));
    assign handshake = m_req & bus.m_gnt_i;
    assign pop       = bus.m_rvalid_i & ~fifo_empty;

    // --------------------------------------------------------- payload mux
    always_comb begin
        addr_mux  = '0;
        we_mux    = 1'b0;
        wdata_mux = '0;
        be_mux    = '0;
        if (m_req) begin
            addr_mux  = bus.s_addr_i[sel];
            we_mux    = bus.s_we_i[sel];
            wdata_mux = bus.s_wdata_i[sel];
            be_mux    = bus.s_be_i[sel];
        end
    end

    // -------------------------------------------------- per-requester outputs
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign gnt_vec[gi]    = handshake & (sel == IDXW'(gi));
        assign rvalid_vec[gi] = pop & (fifo_head == IDXW'(gi));
        // Read data is broadcast; only s_rvalid_o tells a requester it is theirs.
        assign rdata_vec[gi]  = arst_ni ? bus.m_rdata_i : '0;
    end

    assign bus.m_req_o    = m_req;
    assign bus.m_addr_o   = addr_mux;
    assign bus.m_we_o     = we_mux;
    assign bus.m_wdata_o  = wdata_mux;
    assign bus.m_be_o     = be_mux;
    assign bus.s_gnt_o    = gnt_vec;
    assign bus.s_rvalid_o = rvalid_vec;
    assign bus.s_rdata_o  = rdata_vec;
    assign err_o          = err_q;

    // ------------------------------------------------------------ next state
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        err_d        = err_q;

        if (handshake) begin
            rr_ptr_d = (sel == IDXW'(NUM_REQ - 1)) ? '0 : sel + IDXW'(1);
            lock_d   = 1'b0;
        end else if (m_req) begin
            // Address phase presented but not accepted: hold this winner.
            lock_d       = 1'b1;
            locked_idx_d = sel;
        end

        // Dropping req during a held address phase is an OBI violation; the
        // arbiter keeps requesting on its behalf and only flags it.
        if (lock_q && !bus.s_req_i[locked_idx_q]) begin
            err_d = 1'b1;
        end
        // Response with no transaction outstanding.
        if (bus.m_rvalid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
            err_q        <= err_d;
        end
    end

    // ------------------------------------------------------------- ID FIFO
    // The full guard on push is redundant with m_req gating but keeps the
    // FIFO self-protecting.
    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .IDXW  (IDXW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .push_i  (handshake & ~fifo_full),
        .data_i  (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obi_rr_arbiter
// Self-checking bench for obi_rr_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).
// Inputs are driven 1ns after the rising edge, outputs sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_obi_rr_arbiter;
    import obi_arb_pkg::*;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic arst_ni;
    logic err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    obi_rr_arbiter_if #(.NUM_REQ(NR), .OBI_ADDRW(AW), .OBI_DATAW(DW), .OBI_STRBW(SW)) bus ();

    obi_rr_arbiter #(
        .NUM_REQ(NR), .OBI_ADDRW(AW), .OBI_DATAW(DW), .OBI_STRBW(SW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i   (clk),
        .arst_ni (arst_ni),
        .bus     (bus),
        .err_o   (err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        bus.s_req_i    = '0;
        bus.s_addr_i   = '0;
        bus.s_we_i     = '0;
        bus.s_wdata_i  = '0;
        bus.s_be_i     = '0;
        bus.m_gnt_i    = 1'b0;
        bus.m_rvalid_i = 1'b0;
        bus.m_rdata_i  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        next_cycle();
        arst_ni = 1'b0;
        idle_inputs();
        #2;
        chk("reset_err_clear", err, 1'b0);
        chk("reset_mreq", bus.m_req_o, 1'b0);
        next_cycle();
        arst_ni = 1'b1;
    endtask

    // Table vectors: one cycle each, applied in order from a fresh reset.
    typedef struct packed {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        x_mreq;
        logic [31:0] x_addr;
        logic [1:0]  x_gnt;
        logic [1:0]  x_rv;
    } vec_t;

    function automatic vec_t mkv(logic [1:0] req, logic [31:0] a0, logic [31:0] a1,
                                 logic gnt, logic rv, logic [31:0] rdata, logic x_mreq,
                                 logic [31:0] x_addr, logic [1:0] x_gnt, logic [1:0] x_rv);
        vec_t v;
        v.req = req; v.a0 = a0; v.a1 = a1; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.x_mreq = x_mreq; v.x_addr = x_addr; v.x_gnt = x_gnt; v.x_rv = x_rv;
        return v;
    endfunction

    vec_t tv[12];

    // reference model state for the random phase
    int            q[$];
    int            rr;
    int            held;
    bit            act[NR];
    obi_req_info_t info[NR];

    task automatic new_info(input int p);
        info[p].addr  = $urandom();
        info[p].we    = 1'($urandom_range(0, 1));
        info[p].wdata = $urandom();
        info[p].be    = 4'($urandom_range(0, 15));
    endtask

    initial begin
        logic [1:0]  exp_gnt, exp_rv;
        logic        exp_mreq, any, g, r;
        logic [31:0] rd;
        int          win, p, prev, cnt0, cnt1;
        logic [1:0]  full_gnt[11];
        logic [1:0]  full_rv[11];
        logic        full_mreq[11];

        // ---------------------------------------------------------- reset hold
        arst_ni = 1'b0;
        idle_inputs();
        bus.s_req_i    = 2'b11;
        bus.s_addr_i   = {32'h1111_0000, 32'h2222_0000};
        bus.m_gnt_i    = 1'b1;
        bus.m_rvalid_i = 1'b1;
        bus.m_rdata_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            chk("rst_mreq", bus.m_req_o, 1'b0);
            chk("rst_sgnt", bus.s_gnt_o, 2'b00);
            chk("rst_err", err, 1'b0);
            chk("rst_srv", bus.s_rvalid_o, 2'b00);
            chk("rst_maddr", bus.m_addr_o, 32'h0);
            chk("rst_srdata", bus.s_rdata_o, 64'h0);
        end
        next_cycle();
        arst_ni = 1'b1;
        idle_inputs();

        // ----------------------------------------------- single req + lock table
        tv[0]  = mkv(2'b01, 32'hAB,  32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'hAB,  2'b00, 2'b00);
        tv[1]  = mkv(2'b01, 32'hAB,  32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'hAB,  2'b00, 2'b00);
        tv[2]  = mkv(2'b01, 32'hAB,  32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'hAB,  2'b01, 2'b00);
        tv[3]  = mkv(2'b00, 32'hAB,  32'h0,   1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,   2'b00, 2'b01);
        tv[4]  = mkv(2'b01, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100, 2'b00, 2'b00);
        tv[5]  = mkv(2'b11, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100, 2'b00, 2'b00);
        tv[6]  = mkv(2'b11, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100, 2'b00, 2'b00);
        tv[7]  = mkv(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0,         1'b1, 32'h100, 2'b01, 2'b00);
        tv[8]  = mkv(2'b10, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0,         1'b1, 32'h200, 2'b10, 2'b00);
        tv[9]  = mkv(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'h55,        1'b0, 32'h0,   2'b00, 2'b01);
        tv[10] = mkv(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'h66,        1'b0, 32'h0,   2'b00, 2'b10);
        tv[11] = mkv(2'b00, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   2'b00, 2'b00);
        for (int i = 0; i < 12; i++) begin
            bus.s_req_i      = tv[i].req;
            bus.s_addr_i[0]  = tv[i].a0;
            bus.s_addr_i[1]  = tv[i].a1;
            bus.s_wdata_i[0] = tv[i].a0 + 32'd1;
            bus.s_wdata_i[1] = tv[i].a1 + 32'd1;
            bus.s_we_i       = 2'b00;
            bus.s_be_i       = 8'hFF;
            bus.m_gnt_i      = tv[i].gnt;
            bus.m_rvalid_i   = tv[i].rv;
            bus.m_rdata_i    = tv[i].rdata;
            @(negedge clk);
            chk($sformatf("tv%0d_mreq", i), bus.m_req_o, tv[i].x_mreq);
            chk($sformatf("tv%0d_maddr", i), bus.m_addr_o, tv[i].x_addr);
            chk($sformatf("tv%0d_mwdata", i), bus.m_wdata_o,
                tv[i].x_mreq ? tv[i].x_addr + 32'd1 : 32'h0);
            chk($sformatf("tv%0d_sgnt", i), bus.s_gnt_o, tv[i].x_gnt);
            chk($sformatf("tv%0d_srv", i), bus.s_rvalid_o, tv[i].x_rv);
            chk($sformatf("tv%0d_srdata", i), bus.s_rdata_o[0], tv[i].rdata);
            chk($sformatf("tv%0d_err", i), err, 1'b0);
            next_cycle();
        end
        idle_inputs();

        // ------------------------------------------------------------ fairness
        cnt0 = 0; cnt1 = 0; prev = 0;
        for (int i = 0; i < 9; i++) begin
            bus.s_req_i    = (i < 8) ? 2'b11 : 2'b00;
            bus.m_gnt_i    = (i < 8);
            bus.m_rvalid_i = (i > 0);
            bus.m_rdata_i  = 32'(i);
            @(negedge clk);
            exp_gnt = 2'b00;
            if (i < 8) exp_gnt[i % 2] = 1'b1;
            exp_rv = 2'b00;
            if (i > 0) exp_rv[prev] = 1'b1;
            chk($sformatf("fair%0d_sgnt", i), bus.s_gnt_o, exp_gnt);
            chk($sformatf("fair%0d_srv", i), bus.s_rvalid_o, exp_rv);
            if (bus.s_gnt_o[0]) cnt0++;
            if (bus.s_gnt_o[1]) cnt1++;
            prev = i % 2;
            next_cycle();
        end
        chk("fair_cnt0", 32'(cnt0), 32'd4);
        chk("fair_cnt1", 32'(cnt1), 32'd4);
        idle_inputs();

        // ------------------------------------------------------ full / ordering
        full_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        full_rv   = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        full_mreq = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.s_req_i    = (i < 7) ? 2'b11 : 2'b00;
            bus.m_gnt_i    = (i < 7);
            bus.m_rvalid_i = (i >= 5 && i < 10);
            bus.m_rdata_i  = 32'hA + 32'(i) - 32'd5;
            @(negedge clk);
            chk($sformatf("full%0d_mreq", i), bus.m_req_o, full_mreq[i]);
            chk($sformatf("full%0d_sgnt", i), bus.s_gnt_o, full_gnt[i]);
            chk($sformatf("full%0d_srv", i), bus.s_rvalid_o, full_rv[i]);
            if (full_rv[i] != 2'b00)
                chk($sformatf("full%0d_srdata", i), bus.s_rdata_o[full_rv[i][1]],
                    32'hA + 32'(i) - 32'd5);
            next_cycle();
        end
        chk("full_err", err, 1'b0);
        idle_inputs();

        // ------------------------------------------------------------ underflow
        bus.m_rvalid_i = 1'b1;
        bus.m_rdata_i  = 32'h77;
        @(negedge clk);
        chk("uf_srv", bus.s_rvalid_o, 2'b00);
        chk("uf_err_before", err, 1'b0);
        next_cycle();
        bus.m_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("uf_err_sticky%0d", i), err, 1'b1);
            next_cycle();
        end
        pulse_reset();

        // ------------------------------------------- request dropped while locked
        bus.s_req_i     = 2'b01;
        bus.s_addr_i[0] = 32'h300;
        @(negedge clk);
        chk("ld_mreq0", bus.m_req_o, 1'b1);
        next_cycle();
        bus.s_req_i = 2'b00;
        @(negedge clk);
        chk("ld_mreq1", bus.m_req_o, 1'b1);
        chk("ld_maddr1", bus.m_addr_o, 32'h300);
        chk("ld_err1", err, 1'b0);
        next_cycle();
        bus.m_gnt_i = 1'b1;
        @(negedge clk);
        chk("ld_err2", err, 1'b1);
        chk("ld_sgnt2", bus.s_gnt_o, 2'b01);
        next_cycle();
        idle_inputs();
        // one transaction is outstanding; reset drops it
        pulse_reset();
        bus.m_rvalid_i = 1'b1;
        @(negedge clk);
        chk("post_rst_srv", bus.s_rvalid_o, 2'b00);
        next_cycle();
        bus.m_rvalid_i = 1'b0;
        @(negedge clk);
        chk("post_rst_err", err, 1'b1);
        pulse_reset();

        // ------------------------------------------------ randomized vs. model
        q.delete();
        rr = 0;
        held = -1;
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < NR; k++) begin
            act[k] = 1'b0;
            new_info(k);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < NR; k++) begin
                bus.s_req_i[k]   = act[k];
                bus.s_addr_i[k]  = info[k].addr;
                bus.s_we_i[k]    = info[k].we;
                bus.s_wdata_i[k] = info[k].wdata;
                bus.s_be_i[k]    = info[k].be;
            end
            g  = ($urandom_range(0, 99) < 60);
            r  = (q.size() > 0) && ($urandom_range(0, 99) < 50);
            rd = $urandom();
            bus.m_gnt_i    = g;
            bus.m_rvalid_i = r;
            bus.m_rdata_i  = rd;
            @(negedge clk);

            // expected behaviour from the arbitration rules
            any = 1'b0;
            for (int k = 0; k < NR; k++) any |= act[k];
            win = held;
            if (held < 0) begin
                for (int off = 0; off < NR; off++) begin
                    p = (rr + off) % NR;
                    if (win < 0 && act[p]) win = p;
                end
            end
            exp_mreq = ((held >= 0) || any) && (q.size() < MO);
            exp_gnt  = 2'b00;
            if (exp_mreq && g) exp_gnt[win] = 1'b1;
            exp_rv = 2'b00;
            if (r && q.size() > 0) exp_rv[q[0]] = 1'b1;

            chk("rnd_mreq", bus.m_req_o, exp_mreq);
            chk("rnd_sgnt", bus.s_gnt_o, exp_gnt);
            chk("rnd_srv", bus.s_rvalid_o, exp_rv);
            chk("rnd_err", err, 1'b0);
            chk("rnd_srdata", bus.s_rdata_o[1], rd);
            if (exp_mreq) begin
                chk("rnd_maddr", bus.m_addr_o, info[win].addr);
                chk("rnd_mwe", bus.m_we_o, info[win].we);
                chk("rnd_mwdata", bus.m_wdata_o, info[win].wdata);
                chk("rnd_mbe", bus.m_be_o, info[win].be);
            end

            if (exp_rv != 2'b00) void'(q.pop_front());
            if (exp_gnt != 2'b00) begin
                q.push_back(win);
                rr   = (win + 1) % NR;
                held = -1;
                if (win == 0) cnt0++; else cnt1++;
            end else if (exp_mreq) begin
                held = win;
            end

            for (int k = 0; k < NR; k++) begin
                if (exp_gnt[k]) begin
                    act[k] = 1'($urandom_range(0, 1));
                    if (act[k]) new_info(k);
                end else if (!act[k] && $urandom_range(0, 2) == 0) begin
                    act[k] = 1'b1;
                    new_info(k);
                end
            end
            next_cycle();
        end
        chk("rnd_granted_any", 32'(((cnt0 > 0) && (cnt1 > 0)) ? 1 : 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
